systolic_array_os: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine, successor to the fixed 4x4 array. Computes C = A x B, where A is ROWS x K and B is K x COLS, with K set per job (1..K_MAX). Operands stream in one K-slice per beat under a valid/ready handshake, with internal skewing. The ROWS x COLS accumulator tile is then drained one row per beat. It sits between the operand buffers and the result writeback path of the tile datapath.

---
 rtl/systolic_array_os.sv | 271 +++++++++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os.sv
// Output-stationary systolic matrix-multiply engine: C = A x B.
// Operand beats are skewed into a ROWS x COLS PE grid, each PE accumulates
// its own C element, then the tile is drained one row per beat.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; ready never depends combinationally on valid, and c_out/out_row
// hold their values while out_valid is high and out_ready is low.
module systolic_array_os #(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int K_MAX  = 256,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   a_in,
  input  logic [COLS*DATA_W-1:0]   b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*ACC_W-1:0]    c_out,
  output logic [RW-1:0]            out_row,
  output logic                     busy,
  output logic                     done
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          clear;
  logic          hs;

  // Skew shift registers (row i uses taps 0..i-1, column j uses 0..j-1).
  logic [DATA_W-1:0] a_sk_q [ROWS][ROWS], a_sk_d [ROWS][ROWS];
  logic              av_sk_q[ROWS][ROWS], av_sk_d[ROWS][ROWS];
  logic [DATA_W-1:0] b_sk_q [COLS][COLS], b_sk_d [COLS][COLS];
  logic              bv_sk_q[COLS][COLS], bv_sk_d[COLS][COLS];
  logic [DATA_W-1:0] a_edge [ROWS];
  logic              av_edge[ROWS];
  logic [DATA_W-1:0] b_edge [COLS];
  logic              bv_edge[COLS];

  // PE grid registers and the operands arriving at each PE this cycle.
  logic [DATA_W-1:0] pe_a_q [ROWS][COLS], pe_a_d [ROWS][COLS];
  logic [DATA_W-1:0] pe_b_q [ROWS][COLS], pe_b_d [ROWS][COLS];
  logic              pe_av_q[ROWS][COLS], pe_av_d[ROWS][COLS];
  logic              pe_bv_q[ROWS][COLS], pe_bv_d[ROWS][COLS];
  logic [ACC_W-1:0]  acc_q  [ROWS][COLS], acc_d  [ROWS][COLS];
  logic [DATA_W-1:0] pa_in  [ROWS][COLS];
  logic [DATA_W-1:0] pb_in  [ROWS][COLS];
  logic              pav_in [ROWS][COLS];
  logic              pbv_in [ROWS][COLS];

  assign hs      = in_valid & in_ready;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign out_row = row_q;

  // Job control: next state, counters and handshake strobes.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    flush_d   = flush_q;
    row_d     = row_q;
    done_d    = 1'b0;
    clear     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          k_d     = (k_len > K_MAX_V) ? K_MAX_V : k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == k_q - 1'b1) begin
            state_d = S_FLUSH;
            flush_d = '0;
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FLUSH_LAST) begin
          state_d = S_DRAIN;
          row_d   = '0;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Operands reaching the array edges and each PE input port.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_edge[i]  = a_in[i*DATA_W +: DATA_W];
      av_edge[i] = hs;
    end
    for (int i = 1; i < ROWS; i++) begin
      a_edge[i]  = a_sk_q[i][i-1];
      av_edge[i] = av_sk_q[i][i-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_edge[j]  = b_in[j*DATA_W +: DATA_W];
      bv_edge[j] = hs;
    end
    for (int j = 1; j < COLS; j++) begin
      b_edge[j]  = b_sk_q[j][j-1];
      bv_edge[j] = bv_sk_q[j][j-1];
    end
    for (int i = 0; i < ROWS; i++) begin
      pa_in[i][0]  = a_edge[i];
      pav_in[i][0] = av_edge[i];
      for (int j = 1; j < COLS; j++) begin
        pa_in[i][j]  = pe_a_q[i][j-1];
        pav_in[i][j] = pe_av_q[i][j-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      pb_in[0][j]  = b_edge[j];
      pbv_in[0][j] = bv_edge[j];
      for (int i = 1; i < ROWS; i++) begin
        pb_in[i][j]  = pe_b_q[i-1][j];
        pbv_in[i][j] = pe_bv_q[i-1][j];
      end
    end
  end

  // Next values for skew chains, PE forwarding registers and accumulators.
  always_comb begin
    logic signed [2*DATA_W-1:0] ax, bx, prod;
    ax   = '0;
    bx   = '0;
    prod = '0;
    for (int i = 0; i < ROWS; i++) begin
      a_sk_d[i][0]  = a_in[i*DATA_W +: DATA_W];
      av_sk_d[i][0] = hs;
      for (int d = 1; d < ROWS; d++) begin
        a_sk_d[i][d]  = a_sk_q[i][d-1];
        av_sk_d[i][d] = av_sk_q[i][d-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      b_sk_d[j][0]  = b_in[j*DATA_W +: DATA_W];
      bv_sk_d[j][0] = hs;
      for (int d = 1; d < COLS; d++) begin
        b_sk_d[j][d]  = b_sk_q[j][d-1];
        bv_sk_d[j][d] = bv_sk_q[j][d-1];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        pe_a_d[i][j]  = pa_in[i][j];
        pe_b_d[i][j]  = pb_in[i][j];
        pe_av_d[i][j] = pav_in[i][j];
        pe_bv_d[i][j] = pbv_in[i][j];
        ax   = {{DATA_W{pa_in[i][j][DATA_W-1]}}, pa_in[i][j]};
        bx   = {{DATA_W{pb_in[i][j][DATA_W-1]}}, pb_in[i][j]};
        prod = ax * bx;
        acc_d[i][j] = acc_q[i][j];
        if (pav_in[i][j] && pbv_in[i][j]) begin
          acc_d[i][j] = acc_q[i][j] + ACC_W'(prod);
        end
      end
    end
    // An accepted start wipes every trace of the previous job.
    if (clear) begin
      a_sk_d  = '{default: '0};
      av_sk_d = '{default: '0};
      b_sk_d  = '{default: '0};
      bv_sk_d = '{default: '0};
      pe_a_d  = '{default: '0};
      pe_b_d  = '{default: '0};
      pe_av_d = '{default: '0};
      pe_bv_d = '{default: '0};
      acc_d   = '{default: '0};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sk_q  <= '{default: '0};
      av_sk_q <= '{default: '0};
      b_sk_q  <= '{default: '0};
      bv_sk_q <= '{default: '0};
      pe_a_q  <= '{default: '0};
      pe_b_q  <= '{default: '0};
      pe_av_q <= '{default: '0};
      pe_bv_q <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      a_sk_q  <= a_sk_d;
      av_sk_q <= av_sk_d;
      b_sk_q  <= b_sk_d;
      bv_sk_q <= bv_sk_d;
      pe_a_q  <= pe_a_d;
      pe_b_q  <= pe_b_d;
      pe_av_q <= pe_av_d;
      pe_bv_q <= pe_bv_d;
      acc_q   <= acc_d;
    end
  end

  // Result row mux; zero whenever no row is being offered.
  always_comb begin
    c_out = '0;
    if (out_valid) begin
      for (int j = 0; j < COLS; j++) begin
        c_out[j*ACC_W +: ACC_W] = acc_q[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: a 4x4/32-bit array, a 4x4/16-bit array on the
// same stimulus (wrap behaviour) and a 2x5 array, checked against plain
// matrix products computed from the operand tables.
module tb_systolic_array_os;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int DW  = 8;
  localparam int KM  = 256;
  localparam int KW  = 9;
  localparam int NR  = 2;
  localparam int NC  = 5;
  localparam int NKM = 16;
  localparam int NKW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic           start = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic           in_valid = 1'b0;
  logic [R*DW-1:0] a_in = '0;
  logic [C*DW-1:0] b_in = '0;
  logic           out_ready = 1'b1;
  logic           in_ready, out_valid, busy, done;
  logic [C*32-1:0] c_out;
  logic [1:0]     out_row;
  logic           w_in_ready, w_out_valid, w_busy, w_done;
  logic [C*16-1:0] w_c_out;
  logic [1:0]     w_out_row;

  logic            ns_start = 1'b0;
  logic [NKW-1:0]  ns_k_len = '0;
  logic            ns_in_valid = 1'b0;
  logic [NR*DW-1:0] ns_a_in = '0;
  logic [NC*DW-1:0] ns_b_in = '0;
  logic            ns_out_ready = 1'b1;
  logic            ns_in_ready, ns_out_valid, ns_busy, ns_done;
  logic [NC*32-1:0] ns_c_out;
  logic            ns_out_row;

  systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32), .K_MAX(KM)) u_main (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .out_row(out_row), .busy(busy), .done(done));

  systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16), .K_MAX(KM)) u_w16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(w_in_ready), .a_in(a_in), .b_in(b_in), .out_valid(w_out_valid),
    .out_ready(out_ready), .c_out(w_c_out), .out_row(w_out_row), .busy(w_busy), .done(w_done));

  systolic_array_os #(.ROWS(NR), .COLS(NC), .DATA_W(DW), .ACC_W(32), .K_MAX(NKM)) u_ns (
    .clk(clk), .rst(rst), .start(ns_start), .k_len(ns_k_len), .in_valid(ns_in_valid),
    .in_ready(ns_in_ready), .a_in(ns_a_in), .b_in(ns_b_in), .out_valid(ns_out_valid),
    .out_ready(ns_out_ready), .c_out(ns_c_out), .out_row(ns_out_row), .busy(ns_busy), .done(ns_done));

  // ---------------- model state ----------------
  int ma [R][KM];
  int mb [KM][C];
  int nma[NR][NKM];
  int nmb[NKM][NC];
  logic [C*32-1:0] exp_q[$];
  logic [C*16-1:0] exp16_q[$];
  logic [1:0]      exprow_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int start_edge = 0;
  logic stall_en = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain matrix product over the first k beats, one expected row per entry.
  task automatic push_expected(input int k);
    logic [C*32-1:0] row;
    logic [C*16-1:0] row16;
    int s;
    for (int r = 0; r < R; r++) begin
      row = '0;
      row16 = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) s += ma[r][t] * mb[t][j];
        row[j*32 +: 32] = s;
        row16[j*16 +: 16] = s[15:0];
      end
      exp_q.push_back(row);
      exp16_q.push_back(row16);
      exprow_q.push_back(r[1:0]);
    end
  endtask

  task automatic fill_random(input int k);
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < R; i++) ma[i][t] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < C; j++) mb[t][j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic start_main(input int kl);
    start = 1'b1;
    k_len = kl[KW-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic stream_main(input int k, input int gap, input bit inj);
    int  t = 0;
    int  guard = 0;
    bit  hs;
    while (t < k && guard < 4000) begin
      in_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      for (int i = 0; i < R; i++) a_in[i*DW +: DW] = ma[i][t][DW-1:0];
      for (int j = 0; j < C; j++) b_in[j*DW +: DW] = mb[t][j][DW-1:0];
      if (inj) begin
        start = (t == 2);
        k_len = 9'd5;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) t++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("stream_beats", t, k);
  endtask

  task automatic finish_main(input int k, input bit timed);
    int first_ov = -1;
    bit got = 1'b0;
    int ir_hi = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (in_ready) ir_hi++;
      if (out_valid && first_ov < 0) first_ov = cyc - start_edge;
      if (done) begin
        got = 1'b1;
        check("busy_low_at_done", busy, 1'b0);
        if (timed) check("done_latency", cyc - start_edge, k + R + C + R - 1);
      end
    end
    check("done_seen", got, 1'b1);
    if (timed) check("first_out_valid", first_ov, k + R + C - 1);
    if (k == 0) check("k0_no_in_ready", ir_hi, 0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_c_out"}, c_out, '0);
    check({tag, "_out_row"}, out_row, '0);
  endtask

  // ---------------- scoreboard compare ----------------
  logic            hold_v = 1'b0;
  logic [C*32-1:0] hold_c;
  logic [1:0]      hold_r;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_c_out", c_out, hold_c);
        check("stall_out_row", out_row, hold_r);
      end
      hold_v = out_valid && !out_ready;
      hold_c = c_out;
      hold_r = out_row;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_row", 1'b1, 1'b0);
        end else begin
          check("c_out", c_out, exp_q.pop_front());
          check("out_row", out_row, exprow_q.pop_front());
        end
      end
      if (w_out_valid && out_ready) begin
        if (exp16_q.size() == 0) check("unexpected_row16", 1'b1, 1'b0);
        else check("c_out_w16", w_c_out, exp16_q.pop_front());
      end
    end
  end

  // ---------------- 2x5 job ----------------
  task automatic run_ns(input int k);
    logic [NC*32-1:0] nexp[NR];
    int s;
    int t = 0;
    int rows = 0;
    int first_ov = -1;
    int st;
    bit hs;
    bit got = 1'b0;
    for (int tt = 0; tt < k; tt++) begin
      for (int i = 0; i < NR; i++) nma[i][tt] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < NC; j++) nmb[tt][j] = int'($urandom_range(0, 255)) - 128;
    end
    for (int r = 0; r < NR; r++) begin
      nexp[r] = '0;
      for (int j = 0; j < NC; j++) begin
        s = 0;
        for (int tt = 0; tt < k; tt++) s += nma[r][tt] * nmb[tt][j];
        nexp[r][j*32 +: 32] = s;
      end
    end
    ns_start = 1'b1;
    ns_k_len = k[NKW-1:0];
    @(posedge clk);
    #1;
    ns_start = 1'b0;
    st = cyc;
    for (int g = 0; g < 200 && t < k; g++) begin
      ns_in_valid = 1'b1;
      for (int i = 0; i < NR; i++) ns_a_in[i*DW +: DW] = nma[i][t][DW-1:0];
      for (int j = 0; j < NC; j++) ns_b_in[j*DW +: DW] = nmb[t][j][DW-1:0];
      @(negedge clk);
      hs = ns_in_valid && ns_in_ready;
      @(posedge clk);
      #1;
      if (hs) t++;
    end
    ns_in_valid = 1'b0;
    check("ns_stream_beats", t, k);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (ns_out_valid) begin
        if (first_ov < 0) first_ov = cyc - st;
        if (rows < NR) begin
          check("ns_c_out", ns_c_out, nexp[rows]);
          check("ns_out_row", ns_out_row, rows);
        end
        rows++;
      end
      if (ns_done) got = 1'b1;
    end
    check("ns_first_out_valid", first_ov, k + NR + NC - 1);
    check("ns_rows", rows, NR);
    check("ns_done_seen", got, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [C*32-1:0] pin32;
    logic [C*16-1:0] pin16;
    logic [31:0]     word;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk);
    #1;

    // Identity A, B[t][j] = 4t + j, continuous valid.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < R; i++) ma[i][t] = (i == t) ? 1 : 0;
      for (int j = 0; j < C; j++) mb[t][j] = 4 * t + j;
    end
    push_expected(4);
    pin32 = exp_q[2];
    check("model_identity_row2", pin32, {32'd11, 32'd10, 32'd9, 32'd8});
    start_main(4);
    stream_main(4, 0, 1'b0);
    finish_main(4, 1'b1);

    // Signed extremes: 256 x (-128 * -128).
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < R; i++) ma[i][t] = -128;
      for (int j = 0; j < C; j++) mb[t][j] = -128;
    end
    push_expected(256);
    pin32 = exp_q[0];
    pin16 = exp16_q[0];
    check("model_extreme32", pin32, {4{32'h0040_0000}});
    check("model_extreme16", pin16, 64'h0);
    start_main(256);
    stream_main(256, 0, 1'b0);
    finish_main(256, 1'b1);

    // Random 4x4x17 with input bubbles and output stalls.
    fill_random(17);
    push_expected(17);
    stall_en = 1'b1;
    start_main(17);
    stream_main(17, 35, 1'b0);
    finish_main(17, 1'b0);
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // k_len = 0: zero rows without any operand beat.
    push_expected(0);
    start_main(0);
    finish_main(0, 1'b0);

    // start pulsed during STREAM must not disturb the running job.
    fill_random(6);
    push_expected(6);
    start_main(6);
    stream_main(6, 0, 1'b1);
    finish_main(6, 1'b1);

    // Reset one cycle into FLUSH, then a clean K=3 job.
    fill_random(5);
    start_main(5);
    stream_main(5, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp16_q.delete();
    exprow_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_flush_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_random(3);
    push_expected(3);
    start_main(3);
    stream_main(3, 0, 1'b0);
    finish_main(3, 1'b1);

    // k_len above K_MAX runs as K_MAX beats of 1 x 1.
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < R; i++) ma[i][t] = 1;
      for (int j = 0; j < C; j++) mb[t][j] = 1;
    end
    push_expected(256);
    pin32 = exp_q[0];
    word = pin32[31:0];
    check("model_clamp", word, 32'd256);
    start_main(300);
    stream_main(256, 0, 1'b0);
    finish_main(256, 1'b1);

    // Non-square 2x5 array, K=7.
    run_ns(7);

    repeat (3) @(posedge clk);
    check("rows_left_over", exp_q.size(), 0);
    check("rows16_left_over", exp16_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
